// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit holding the architectural HI/LO pair.
// mult/div results are computed combinationally from latched operands and
// committed after a fixed latency; mthi/mtlo write in a single cycle.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        md_start,
  input  logic [2:0]  md_sel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;

  logic        is_signed;
  logic        is_mult;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] mag_q;
  logic [31:0] mag_r;
  logic [31:0] div_q;
  logic [31:0] div_r;

  // Result datapath: sign-extended 64-bit multiply and sign-magnitude divide
  always_comb begin
    is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
    is_mult   = (op_q == OP_MULT) || (op_q == OP_MULTU);
    ext_a     = is_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    ext_b     = is_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod      = ext_a * ext_b;
    neg_a     = (op_q == OP_DIV) && a_q[31];
    neg_b     = (op_q == OP_DIV) && b_q[31];
    // Magnitudes stay unsigned, so 0x80000000 / -1 needs no special case
    mag_a     = neg_a ? (32'd0 - a_q) : a_q;
    mag_b     = neg_b ? (32'd0 - b_q) : b_q;
    mag_q     = 32'd0;
    mag_r     = 32'd0;
    if (mag_b != 32'd0) begin
      mag_q = mag_a / mag_b;
      mag_r = mag_a % mag_b;
    end
    div_q = (neg_a ^ neg_b) ? (32'd0 - mag_q) : mag_q;
    div_r = neg_a ? (32'd0 - mag_r) : mag_r;
  end

  // Control FSM, latency counter, operand latches and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (md_start) begin
            case (md_sel)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                op_q  <= md_sel;
                a_q   <= rs_val;
                b_q   <= rt_val;
                cnt   <= ((md_sel == OP_MULT) || (md_sel == OP_MULTU)) ?
                         CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                state <= RUN;
                busy  <= 1'b1;
              end
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
            if (is_mult) begin
              hi <= prod[63:32];
              lo <= prod[31:0];
            end else if (b_q != 32'd0) begin
              hi <= div_r;
              lo <= div_q;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: table vectors, hand sequences and random ops against a
// plain-arithmetic HI/LO reference model.
module tb_md_unit;

  logic        clk;
  logic        rst_n;
  logic        md_start;
  logic [2:0]  md_sel;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .md_start(md_start), .md_sel(md_sel),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          preload;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [2:0]  sel;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics with wide integer arithmetic
  task automatic ref_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                        inout logic [31:0] rh, inout logic [31:0] rl);
    longint      sa, sb, q, r;
    logic [63:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (sel)
      3'd1: begin t = 64'(sa * sb); rh = t[63:32]; rl = t[31:0]; end
      3'd2: begin t = {32'd0, a} * {32'd0, b}; rh = t[63:32]; rl = t[31:0]; end
      3'd3: if (b != 0) begin
              q = sa / sb; r = sa % sb;
              t = 64'(q); rl = t[31:0];
              t = 64'(r); rh = t[31:0];
            end
      3'd4: if (b != 0) begin rl = a / b; rh = a % b; end
      3'd5: rh = a;
      3'd6: rl = a;
      default: ;
    endcase
  endtask

  // Issue a mult/div at the current negedge; returns in the done cycle
  task automatic run_md(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
    logic [31:0] e_hi, e_lo, o_hi, o_lo;
    int n, bc, held_bad;
    bit got;
    o_hi = m_hi; o_lo = m_lo;
    e_hi = m_hi; e_lo = m_lo;
    ref_op(sel, a, b, e_hi, e_lo);
    n = (sel <= 3'd2) ? 5 : 10;
    md_start = 1'b1; md_sel = sel; rs_val = a; rt_val = b;
    @(negedge clk);
    md_start = 1'b0; md_sel = 3'd0; rs_val = $urandom; rt_val = $urandom;
    bc = 0; got = 1'b0; held_bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (done) begin got = 1'b1; break; end
      if (busy) bc++;
      if (hi !== o_hi || lo !== o_lo) held_bad++;
      if (poke) begin
        md_start = 1'b1; md_sel = 3'd1; rs_val = $urandom; rt_val = $urandom;
      end
      @(negedge clk);
    end
    md_start = 1'b0; md_sel = 3'd0;
    chk("done_seen", 64'(got), 64'd1);
    chk("busy_cycles", 64'(bc), 64'(n));
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("held_in_run", 64'(held_bad), 64'd0);
    chk("hi", 64'(hi), 64'(e_hi));
    chk("lo", 64'(lo), 64'(e_lo));
    m_hi = e_hi; m_lo = e_lo;
  endtask

  // Single-cycle mthi/mtlo at the current negedge
  task automatic mt(input logic [2:0] sel, input logic [31:0] a);
    md_start = 1'b1; md_sel = sel; rs_val = a;
    @(negedge clk);
    md_start = 1'b0; md_sel = 3'd0;
    ref_op(sel, a, 32'd0, m_hi, m_lo);
    chk("mt_hi", 64'(hi), 64'(m_hi));
    chk("mt_lo", 64'(lo), 64'(m_lo));
    chk("mt_busy", 64'(busy), 64'd0);
    chk("mt_done", 64'(done), 64'd0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 32'd0, 32'd0, 3'd1, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1] = '{1'b0, 32'd0, 32'd0, 3'd2, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{1'b0, 32'd0, 32'd0, 3'd3, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{1'b0, 32'd0, 32'd0, 3'd4, 32'hFFFFFFF9, 32'h2, 32'h00000001, 32'h7FFFFFFC};
    vecs[4] = '{1'b0, 32'd0, 32'd0, 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};
    vecs[5] = '{1'b1, 32'h1234, 32'h5678, 3'd4, 32'hDEADBEEF, 32'h0, 32'h1234, 32'h5678};
    vecs[6] = '{1'b0, 32'd0, 32'd0, 3'd1, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[7] = '{1'b1, 32'hAAAA, 32'hBBBB, 3'd3, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD};

    rst_n = 1'b0; md_start = 1'b0; md_sel = 3'd0; rs_val = 32'd0; rt_val = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].preload) begin
        mt(3'd5, vecs[i].pre_hi);
        mt(3'd6, vecs[i].pre_lo);
      end
      run_md(vecs[i].sel, vecs[i].rs, vecs[i].rt, 1'b0);
      chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
      chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
      @(negedge clk);
      chk("done_one_shot", 64'(done), 64'd0);
    end

    // MTHI then MTLO on consecutive cycles
    mt(3'd5, 32'hCAFEBABE);
    mt(3'd6, 32'h0BADF00D);
    chk("mthi_val", 64'(hi), 64'hCAFEBABE);
    chk("mtlo_val", 64'(lo), 64'h0BADF00D);

    // Reserved and none selects are ignored
    for (int s = 0; s < 8; s += 7) begin
      md_start = 1'b1; md_sel = 3'(s); rs_val = 32'h11111111; rt_val = 32'h3;
      @(negedge clk);
      md_start = 1'b0;
      chk("ign_busy", 64'(busy), 64'd0);
      chk("ign_hi", 64'(hi), 64'(m_hi));
      chk("ign_lo", 64'(lo), 64'(m_lo));
      @(negedge clk);
      chk("ign_busy2", 64'(busy), 64'd0);
    end

    // Operand changes and extra requests during RUN are dropped
    run_md(3'd1, 32'd3, 32'd5, 1'b1);
    chk("poke_lo", 64'(lo), 64'd15);
    @(negedge clk);
    chk("poke_dropped_busy", 64'(busy), 64'd0);
    chk("poke_dropped_done", 64'(done), 64'd0);

    // Back-to-back MULT issued in the done cycle
    run_md(3'd1, 32'd6, 32'd7, 1'b0);
    run_md(3'd1, 32'h10000, 32'h10000, 1'b0);
    chk("b2b_hi", 64'(hi), 64'd1);
    @(negedge clk);

    // Randomized ops
    for (int k = 0; k < 30; k++) begin
      logic [2:0]  s;
      logic [31:0] a, b;
      s = 3'($urandom_range(1, 6));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (s >= 3'd5) mt(s, a);
      else begin
        run_md(s, a, b, 1'b0);
        @(negedge clk);
      end
    end

    // Reset during a DIVU abandons it
    mt(3'd5, 32'h5555);
    md_start = 1'b1; md_sel = 3'd4; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    md_start = 1'b0; md_sel = 3'd0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_hi", 64'(hi), 64'd0);
    chk("mid_rst_lo", 64'(lo), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int dcnt;
      dcnt = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (done || busy || hi != 32'd0 || lo != 32'd0) dcnt++;
      end
      chk("no_commit_after_rst", 64'(dcnt), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
